// File: rtl/cache_ctrl_pkg.sv
// Shared types and geometry for the write-back cache miss controller.
// Address split: [31:6] line tag, [5:2] word select, [1:0] byte (ignored).
package cache_ctrl_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 512;
    localparam int OFFSET_W   = 6;
    localparam int TAG_W      = 26;
    localparam int WORD_SEL_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        DONE
    } state_t;

    // Clears the byte offset so the address points at the start of its line.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1 -: TAG_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_ctrl_stats.sv
// Hit / miss / write-back event counters for the cache controller.
// Only instantiated when CACHE_CTRL_STATS_EN is defined; counters wrap modulo 2^32.
module cache_ctrl_stats
    import cache_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hit_evt,
    input  logic              miss_evt,
    input  logic              wb_evt,
    output logic [WORD_W-1:0] stat_hits,
    output logic [WORD_W-1:0] stat_misses,
    output logic [WORD_W-1:0] stat_writebacks
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_hits       <= '0;
            stat_misses     <= '0;
            stat_writebacks <= '0;
        end else begin
            if (hit_evt)  stat_hits       <= stat_hits + 1'b1;
            if (miss_evt) stat_misses     <= stat_misses + 1'b1;
            if (wb_evt)   stat_writebacks <= stat_writebacks + 1'b1;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Miss-handling controller between the CPU word port and a single-line write-back cache.
// Optional event counters are built in when CACHE_CTRL_STATS_EN is defined.
module cache_controller
    import cache_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    output logic [ADDR_W-1:0]  cache_addr,
    output logic               cache_we_word,
    output logic               cache_we_block,
    output logic [WORD_W-1:0]  cache_wdata_word,
    output logic [BLOCK_W-1:0] cache_wdata_block,
    input  logic [WORD_W-1:0]  cache_rdata_word,
    input  logic [BLOCK_W-1:0] cache_rdata_block,
    input  logic               cache_hit,
    input  logic               cache_dirty,
    input  logic [ADDR_W-1:0]  cache_addout,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [WORD_W-1:0]  stat_hits,
    output logic [WORD_W-1:0]  stat_misses,
    output logic [WORD_W-1:0]  stat_writebacks
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_we;
    logic [WORD_W-1:0]   req_wdata;
    logic                refilled;

    // refilled remembers that this request already fetched its line, so the
    // replayed lookup is not counted as a fresh hit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            refilled  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cpu_req) begin
                req_addr  <= cpu_addr;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
                refilled  <= 1'b0;
            end else if (state == REFILL && mem_ack) begin
                refilled  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cpu_ready      = 1'b0;
        cpu_rdata      = '0;
        cache_we_word  = 1'b0;
        cache_we_block = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state)
            IDLE: begin
                if (cpu_req) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (cache_hit) begin
                    cache_we_word = req_we;
                    state_nxt     = DONE;
                end else if (cache_dirty) begin
                    state_nxt = WRITEBACK;
                end else begin
                    state_nxt = REFILL;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_addr(cache_addout);
                mem_wdata = cache_rdata_block;
                if (mem_ack) state_nxt = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = line_addr(req_addr);
                if (mem_ack) begin
                    cache_we_block = 1'b1;
                    state_nxt      = LOOKUP;
                end
            end
            DONE: begin
                cpu_ready = 1'b1;
                cpu_rdata = cache_rdata_word;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cache_addr        = req_addr;
    assign cache_wdata_word  = req_wdata;
    assign cache_wdata_block = mem_rdata;

`ifdef CACHE_CTRL_STATS_EN
    logic hit_evt;
    logic miss_evt;
    logic wb_evt;

    assign hit_evt  = (state == LOOKUP) && cache_hit && !refilled;
    assign miss_evt = (state == LOOKUP) && !cache_hit;
    assign wb_evt   = (state == WRITEBACK) && mem_ack;

    cache_ctrl_stats u_stats (
        .clk             (clk),
        .rst             (rst),
        .hit_evt         (hit_evt),
        .miss_evt        (miss_evt),
        .wb_evt          (wb_evt),
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses),
        .stat_writebacks (stat_writebacks)
    );
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural one-line cache and a
// delayed-ack memory; stat counters are checked when CACHE_CTRL_STATS_EN is defined.
module tb_cache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [31:0]  cache_addr;
    logic         cache_we_word;
    logic         cache_we_block;
    logic [31:0]  cache_wdata_word;
    logic [511:0] cache_wdata_block;
    logic [31:0]  cache_rdata_word;
    logic [511:0] cache_rdata_block;
    logic         cache_hit;
    logic         cache_dirty;
    logic [31:0]  cache_addout;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [511:0] mem_wdata;
    logic [511:0] mem_rdata;
    logic         mem_ack;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;
    logic [31:0]  stat_writebacks;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    cache_controller dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_rdata         (cpu_rdata),
        .cpu_ready         (cpu_ready),
        .cache_addr        (cache_addr),
        .cache_we_word     (cache_we_word),
        .cache_we_block    (cache_we_block),
        .cache_wdata_word  (cache_wdata_word),
        .cache_wdata_block (cache_wdata_block),
        .cache_rdata_word  (cache_rdata_word),
        .cache_rdata_block (cache_rdata_block),
        .cache_hit         (cache_hit),
        .cache_dirty       (cache_dirty),
        .cache_addout      (cache_addout),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .stat_hits         (stat_hits),
        .stat_misses       (stat_misses),
        .stat_writebacks   (stat_writebacks)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: every word holds 0xC0DE0000 xor its own byte address.
    function automatic logic [511:0] line_pat(input logic [31:0] base);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'hC0DE_0000 ^ (base + 32'(4 * i));
        return r;
    endfunction

    // Behavioural single-line write-back cache, registered word read port.
    logic         c_valid = 1'b0;
    logic         c_dirty = 1'b0;
    logic [25:0]  c_line  = '0;
    logic [511:0] c_data  = '0;
    logic [31:0]  c_rword = '0;

    assign cache_hit         = c_valid && (c_line == cache_addr[31:6]);
    assign cache_dirty       = c_valid && c_dirty;
    assign cache_addout      = {c_line, 6'b0};
    assign cache_rdata_block = c_data;
    assign cache_rdata_word  = c_rword;

    always @(posedge clk) begin
        c_rword <= c_data[{cache_addr[5:2], 5'b0} +: 32];
        if (cache_we_block) begin
            c_data  <= cache_wdata_block;
            c_line  <= cache_addr[31:6];
            c_valid <= 1'b1;
            c_dirty <= 1'b0;
        end else if (cache_we_word) begin
            c_data[{cache_addr[5:2], 5'b0} +: 32] <= cache_wdata_word;
            c_dirty <= 1'b1;
        end
    end

    // Memory responder: acks after ack_delay cycles of mem_req.
    int   ack_delay    = 1;
    int   req_cycles   = 0;
    logic spurious_ack = 1'b0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (spurious_ack) begin
                mem_ack = 1'b1;
            end else if (mem_req) begin
                req_cycles++;
                if (req_cycles >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (!mem_we) mem_rdata = line_pat(mem_addr);
                    req_cycles = 0;
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    // Monitor: counts completions and memory bursts, flags unstable requests.
    int           cyc = 0;
    int           ready_count = 0, ready_cyc = 0;
    logic [31:0]  last_rdata = '0;
    int           wb_count = 0, refill_count = 0;
    logic [31:0]  wb_addr = '0, refill_addr = '0;
    logic [511:0] wb_data = '0;
    int           burst_len = 0, wb_len = 0, refill_len = 0;
    int           unstable = 0, req_after_ack = 0;
    logic         prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [31:0]  prev_addr = '0;
    logic [511:0] prev_wdata = '0;

    initial begin
        forever begin
            @(posedge clk);
            #3;
            cyc++;
            if (cpu_ready) begin
                ready_count++;
                last_rdata = cpu_rdata;
                ready_cyc  = cyc;
            end
            if (mem_req) begin
                if (!(prev_req && !prev_ack)) begin
                    burst_len = 0;
                    if (mem_we) begin
                        wb_count++;
                        wb_addr = mem_addr;
                        wb_data = mem_wdata;
                    end else begin
                        refill_count++;
                        refill_addr = mem_addr;
                    end
                end else if (mem_we !== prev_we || mem_addr !== prev_addr || mem_wdata !== prev_wdata) begin
                    unstable++;
                end
                burst_len++;
                if (mem_ack) begin
                    if (mem_we) wb_len = burst_len;
                    else        refill_len = burst_len;
                end
            end
            if (prev_req && prev_ack && !prev_we && mem_req) req_after_ack++;
            prev_req   = mem_req;
            prev_ack   = mem_ack;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One-cycle request, then wait for its completion; optionally pulses a
    // stray cpu_req pulse_at cycles into the wait.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int pulse_at,
                                 output logic [31:0] rdata, output int lat);
        int start_ready;
        int req_cyc;
        int n;
        start_ready = ready_count;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        req_cyc   = cyc;
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        n = 0;
        while (ready_count == start_ready && n < 300) begin
            @(negedge clk);
            n++;
            if (pulse_at != 0 && n == pulse_at) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'b1;
                cpu_addr  = 32'h0000_2000;
                cpu_wdata = 32'h1234_5678;
            end else begin
                cpu_req   = 1'b0;
                cpu_we    = 1'b0;
                cpu_addr  = '0;
                cpu_wdata = '0;
            end
        end
        cpu_req = 1'b0;
        checkOutput({tag, "_ready"}, 32'(ready_count - start_ready), 32'd1);
        rdata = last_rdata;
        lat   = ready_cyc - req_cyc;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] rd;
    int          lat;
    int          base_wb, base_rf, base_rdy;

    initial begin
        rst       = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_we_word", 32'(cache_we_word), 32'd0);
        checkOutput("rst_we_block", 32'(cache_we_block), 32'd0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_cache_addr", cache_addr, 32'd0);
        rst = 1'b1;

        $display("[TB] cold clean miss at 0x40");
        applyStimulus("cold", 1'b0, 32'h0000_0040, 32'h0, 0, rd, lat);
        checkOutput("cold_rdata", rd, 32'hC0DE_0040);
        checkOutput("cold_refills", 32'(refill_count), 32'd1);
        checkOutput("cold_refill_addr", refill_addr, 32'h0000_0040);
        checkOutput("cold_writebacks", 32'(wb_count), 32'd0);
        checkOutput("cold_refill_len", 32'(refill_len), 32'd1);

        $display("[TB] store then load hit at 0x44");
        base_rf = refill_count;
        applyStimulus("store", 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0, rd, lat);
        checkOutput("store_lat", 32'(lat), 32'd2);
        applyStimulus("load44", 1'b0, 32'h0000_0044, 32'h0, 0, rd, lat);
        checkOutput("load44_rdata", rd, 32'hDEAD_BEEF);
        checkOutput("load44_lat", 32'(lat), 32'd2);
        checkOutput("load44_no_mem", 32'(refill_count - base_rf + wb_count), 32'd0);

        $display("[TB] dirty miss at 0x1000, 7-cycle ack, stray cpu_req");
        ack_delay = 7;
        base_rdy  = ready_count;
        applyStimulus("dirty", 1'b0, 32'h0000_1000, 32'h0, 3, rd, lat);
        checkOutput("dirty_rdata", rd, 32'hC0DE_1000);
        checkOutput("dirty_wb_count", 32'(wb_count), 32'd1);
        checkOutput("dirty_wb_addr", wb_addr, 32'h0000_0040);
        checkOutput("dirty_wb_word0", wb_data[31:0], 32'hC0DE_0040);
        checkOutput("dirty_wb_word1", wb_data[63:32], 32'hDEAD_BEEF);
        checkOutput("dirty_refill_addr", refill_addr, 32'h0000_1000);
        checkOutput("dirty_wb_len", 32'(wb_len), 32'd7);
        checkOutput("dirty_refill_len", 32'(refill_len), 32'd7);
        checkOutput("dirty_unstable", 32'(unstable), 32'd0);
        checkOutput("dirty_req_after_ack", 32'(req_after_ack), 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("stray_one_ready", 32'(ready_count - base_rdy), 32'd1);
        checkOutput("stray_mem_idle", 32'(mem_req), 32'd0);

        $display("[TB] spurious mem_ack in IDLE");
        ack_delay = 1;
        base_rf   = refill_count;
        base_rdy  = ready_count;
        @(negedge clk);
        spurious_ack = 1'b1;
        @(negedge clk);
        spurious_ack = 1'b0;
        checkOutput("spur_we_block", 32'(cache_we_block), 32'd0);
        checkOutput("spur_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("spur_no_ready", 32'(ready_count - base_rdy), 32'd0);
        applyStimulus("spur_hit", 1'b0, 32'h0000_1008, 32'h0, 0, rd, lat);
        checkOutput("spur_hit_rdata", rd, 32'hC0DE_1008);
        checkOutput("spur_hit_lat", 32'(lat), 32'd2);
        checkOutput("spur_no_refill", 32'(refill_count - base_rf), 32'd0);
`ifdef CACHE_CTRL_STATS_EN
        checkOutput("stat_hits_mid", stat_hits, 32'd3);
        checkOutput("stat_misses_mid", stat_misses, 32'd2);
        checkOutput("stat_wb_mid", stat_writebacks, 32'd1);
`endif

        $display("[TB] reset during refill");
        ack_delay = 7;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_3000;
        @(negedge clk);
        cpu_req  = 1'b0;
        cpu_addr = '0;
        repeat (3) @(negedge clk);
        checkOutput("abort_refill_active", 32'(mem_req), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
        checkOutput("abort_cpu_ready", 32'(cpu_ready), 32'd0);
        checkOutput("abort_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        ack_delay = 1;
        base_rf = refill_count;
        applyStimulus("after_abort", 1'b0, 32'h0000_3000, 32'h0, 0, rd, lat);
        checkOutput("after_abort_rdata", rd, 32'hC0DE_3000);
        checkOutput("after_abort_refills", 32'(refill_count - base_rf), 32'd1);
        checkOutput("after_abort_addr", refill_addr, 32'h0000_3000);
`ifdef CACHE_CTRL_STATS_EN
        checkOutput("stat_hits_end", stat_hits, 32'd0);
        checkOutput("stat_misses_end", stat_misses, 32'd1);
        checkOutput("stat_wb_end", stat_writebacks, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
